// File: rtl/ece385_cmp_pkg.sv
// ece385_cmp_pkg: shared types and cascade-resolution helper for the sequential magnitude comparator
package ece385_cmp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;
  // Returns {gt, eq, lt}; eq_in=0 follows the 7485 rule, so all-zero inputs yield gt=lt=1
  function automatic logic [2:0] resolve_cascade(input logic eq_in, input logic lt_in, input logic gt_in);
    return eq_in ? 3'b010 : {~lt_in, 1'b0, ~gt_in};
  endfunction
endpackage

// File: rtl/ece385_cmp_slice.sv
// ece385_cmp_slice: combinational SLICE-bit compare (a, b, inv_msb -> res); inv_msb flips both MSBs for signed top slices
module ece385_cmp_slice
  import ece385_cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             inv_msb,
  output cmp_res_t         res
);
  logic [SLICE-1:0] flip, a_f, b_f;
  assign flip = SLICE'(inv_msb) << (SLICE - 1);
  assign a_f  = a ^ flip;
  assign b_f  = b ^ flip;
  assign res  = a_f > b_f ? CMP_GT : a_f < b_f ? CMP_LT : CMP_EQ;
endmodule

// File: rtl/ece385_mag_cmp_seq.sv
// ece385_mag_cmp_seq: MSB-first multi-cycle magnitude comparator; Clk/Reset, Start/Ready in, Is_Signed, A, B, cascade ins; Done pulse and registered gt/eq/lt outs
module ece385_mag_cmp_seq
  import ece385_cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic             Ready,
  input  logic             Is_Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             A_lt_B_in,
  input  logic             A_eq_B_in,
  input  logic             A_gt_B_in,
  output logic             Done,
  output logic             A_gt_B_out,
  output logic             A_eq_B_out,
  output logic             A_lt_B_out
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  cmp_state_t state, state_n;
  cmp_res_t dec, slice_res, cur;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic sgn_q, lt_in_q, eq_in_q, gt_in_q, gt_q, eq_q, lt_q, accept, fin;
  ece385_cmp_slice #(.SLICE(SLICE)) u_slice (
    .a      (a_q[idx*SLICE +: SLICE]),
    .b      (b_q[idx*SLICE +: SLICE]),
    .inv_msb(sgn_q && idx == LAST),
    .res    (slice_res)
  );
  assign accept = Start && state == IDLE;
  // The first unequal slice wins; later slices are only scanned when early exit is off
  assign cur = dec != CMP_EQ ? dec : slice_res;
  assign fin = state == SCAN && ((EARLY_EXIT != 0 && cur != CMP_EQ) || idx == '0);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = accept ? SCAN : fin ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      {a_q, b_q} <= '0;
      {sgn_q, lt_in_q, eq_in_q, gt_in_q} <= '0;
      {gt_q, eq_q, lt_q} <= '0;
      idx <= LAST;
      dec <= CMP_EQ;
    end else if (accept) begin
      {a_q, b_q} <= {A, B};
      {sgn_q, lt_in_q, eq_in_q, gt_in_q} <= {Is_Signed, A_lt_B_in, A_eq_B_in, A_gt_B_in};
      {gt_q, eq_q, lt_q} <= '0;
      idx <= LAST;
      dec <= CMP_EQ;
    end else if (state == SCAN) begin
      dec <= cur;
      if (!fin) idx <= idx - 1'b1;
      if (fin) {gt_q, eq_q, lt_q} <= cur == CMP_GT ? 3'b100 : cur == CMP_LT ? 3'b001 :
                                     resolve_cascade(eq_in_q, lt_in_q, gt_in_q);
    end
  assign Ready      = state == IDLE;
  assign Done       = state == DONE;
  assign A_gt_B_out = gt_q;
  assign A_eq_B_out = eq_q;
  assign A_lt_B_out = lt_q;
endmodule
